// File: rtl/iot_sequencer.sv
// PDP-8 IOT sequencer: timed IOP1/2/4 pulses, skip collection, device 00 interrupt system, IRQ priority.
// Ports: clk, reset_n, start, ir, skip_in, irq, instr_end, int_ack [, iot_wait when IOT_WAIT_EN] -> devsel, iop1/2/4, busy, done, inc_pc, ion, int_req, int_src.
module iot_sequencer #(
  parameter int NDEV  = 4,
  parameter int IOP_W = 2,
  parameter int GAP_W = 1,
  localparam int SW   = (NDEV > 1) ? $clog2(NDEV) : 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [11:0]     ir,
  input  logic            skip_in,
  input  logic [NDEV-1:0] irq,
  input  logic            instr_end,
  input  logic            int_ack,
`ifdef IOT_WAIT_EN
  input  logic            iot_wait,
`endif
  output logic [5:0]      devsel,
  output logic            iop1,
  output logic            iop2,
  output logic            iop4,
  output logic            busy,
  output logic            done,
  output logic            inc_pc,
  output logic            ion,
  output logic            int_req,
  output logic [SW-1:0]   int_src
);

  localparam int MAXW = (IOP_W > GAP_W) ? IOP_W : GAP_W;
  localparam int CW   = $clog2(MAXW + 1);

  typedef enum logic [2:0] {
    IDLE, P1, G1, P2, G2, P4, G4, FIN
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    pend, pend_n;
  logic          acc, acc_n;
  logic [5:0]    devsel_n;
  logic          ion_dly;
  logic          adv;
  logic          go;
  logic          fin_int;

  function automatic state_t first_p(input logic [2:0] b);
    state_t s;
    s = FIN;
    if (b[0])      s = P1;
    else if (b[1]) s = P2;
    else if (b[2]) s = P4;
    return s;
  endfunction

  function automatic logic [2:0] bit_of(input state_t s);
    logic [2:0] m;
    m = 3'b000;
    if (s == P1) m = 3'b001;
    if (s == P2) m = 3'b010;
    if (s == P4) m = 3'b100;
    return m;
  endfunction

  function automatic state_t gap_of(input state_t s);
    state_t g;
    g = G4;
    if (s == P1) g = G1;
    if (s == P2) g = G2;
    return g;
  endfunction

`ifdef IOT_WAIT_EN
  assign go = !iot_wait;
`else
  assign go = 1'b1;
`endif

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    pend_n   = pend;
    acc_n    = acc;
    devsel_n = devsel;
    adv      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && ir[11:9] == 3'b110) begin
          devsel_n = ir[8:3];
          acc_n    = 1'b0;
          cnt_n    = '0;
          pend_n   = 3'b000;
          if (ir[8:3] == 6'd0) begin
            state_n = FIN;
          end else begin
            state_n = first_p(ir[2:0]);
            pend_n  = ir[2:0] & ~bit_of(state_n);
          end
        end
      end
      P1, P2, P4: begin
        if (int'(cnt) == IOP_W - 1) begin
          // Last pulse cycle: held while the device stalls.
          if (go) begin
            acc_n = acc | skip_in;
            cnt_n = '0;
            if (GAP_W > 0) state_n = gap_of(state);
            else           adv     = 1'b1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      G1, G2, G4: begin
        if (int'(cnt) == GAP_W - 1) begin
          cnt_n = '0;
          adv   = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      FIN: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (adv) begin
      state_n = first_p(pend);
      pend_n  = pend & ~bit_of(state_n);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      pend   <= 3'b000;
      acc    <= 1'b0;
      devsel <= 6'd0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      pend   <= pend_n;
      acc    <= acc_n;
      devsel <= devsel_n;
    end
  end

  assign iop1    = (state == P1);
  assign iop2    = (state == P2);
  assign iop4    = (state == P4);
  assign busy    = (state != IDLE);
  assign done    = (state == FIN);
  assign fin_int = done && (devsel == 6'd0);

  always_comb begin
    inc_pc = 1'b0;
    if (done) begin
      if (devsel != 6'd0)          inc_pc = acc;
      else if (ir[2:0] == 3'd0)    inc_pc = ion;
      else if (ir[2:0] == 3'd3)    inc_pc = |irq;
    end
  end

  // INT_ACK beats a same-cycle ION; INSTR_END in the ION's own DONE cycle does not clear the delay.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ion     <= 1'b0;
      ion_dly <= 1'b0;
    end else if (int_ack) begin
      ion     <= 1'b0;
      ion_dly <= 1'b0;
    end else begin
      if (fin_int && (ir[2:0] == 3'd0 || ir[2:0] == 3'd2))
        ion <= 1'b0;
      else if (fin_int && ir[2:0] == 3'd1)
        ion <= 1'b1;
      if (fin_int && ir[2:0] == 3'd1)
        ion_dly <= 1'b1;
      else if (instr_end)
        ion_dly <= 1'b0;
    end
  end

  always_comb begin
    int_src = '0;
    for (int i = NDEV - 1; i >= 0; i--)
      if (irq[i]) int_src = SW'(i);
  end

  assign int_req = ion & (|irq) & ~ion_dly;

endmodule
